// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped data-cache responder.
package dcache_pkg;

    // Default geometry: byte addresses/data, 8 lines, 4-cycle backing RAM.
    localparam int DEF_NBITS   = 8;
    localparam int DEF_NLINES  = 8;
    localparam int DEF_MEM_LAT = 4;
    localparam int DEF_NCNT    = 16;

    // Index bits select the line; everything above them is the tag.
    function automatic int idx_width(input int nlines);
        return $clog2(nlines);
    endfunction

    function automatic int tag_width(input int nbits, input int nlines);
        return nbits - $clog2(nlines);
    endfunction

    // The latency counter counts MEM_LAT-1 down to 0; keep at least one bit.
    function automatic int lat_width(input int mem_lat);
        return (mem_lat > 1) ? $clog2(mem_lat) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_width(DEF_NLINES);
    localparam int DEF_TAG_W = tag_width(DEF_NBITS, DEF_NLINES);
    localparam int DEF_LAT_W = lat_width(DEF_MEM_LAT);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } dcache_state_t;

endpackage

// File: rtl/dcache_responder_if.sv
// Controller <-> cache memory handshake: request, data and the perf counters.
interface dcache_responder_if #(
    parameter int NBITS = 8,
    parameter int NCNT  = 16
);
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] addr;
    logic [NBITS-1:0] wdata;
    logic [NBITS-1:0] rdata;
    logic             busy;
    logic [NCNT-1:0]  read_hits;
    logic [NCNT-1:0]  read_misses;

    // The core side issues requests and holds them stable while busy.
    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, busy, read_hits, read_misses
    );

    // The cache side answers them.
    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, busy, read_hits, read_misses
    );
endinterface

// File: rtl/dcache_responder_mem_backing.sv
// Slow backing data RAM: 2**NBITS bytes, combinational read, synchronous write.
module mem_backing
    import dcache_pkg::*;
#(
    parameter int NBITS = DEF_NBITS
) (
    input  logic             clock,
    input  logic             we_i,
    input  logic [NBITS-1:0] addr_i,
    input  logic [NBITS-1:0] wdata_i,
    output logic [NBITS-1:0] rdata_o
);
    // Contents start at zero and are never cleared by reset.
    logic [NBITS-1:0] mem_q [2**NBITS] = '{default: '0};

    assign rdata_o = mem_q[addr_i];

    // Commit a write-through store on the last cycle of the write latency.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate byte cache that answers the
// controller's MemRead/MemWrite handshake and stalls it with busy.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int NBITS   = DEF_NBITS,
    parameter int NLINES  = DEF_NLINES,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int NCNT    = DEF_NCNT
) (
    input  logic               clock,
    input  logic               reset,
    dcache_responder_if.slave  mem_if
);
    localparam int IDX_W = idx_width(NLINES);
    localparam int TAG_W = tag_width(NBITS, NLINES);
    localparam int LAT_W = lat_width(MEM_LAT);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

    dcache_state_t     state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [NBITS-1:0]  rdata_q, rdata_d;
    logic [NCNT-1:0]   hits_q, hits_d;
    logic [NCNT-1:0]   misses_q, misses_d;

    logic [NLINES-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [NBITS-1:0]  data_q [NLINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              rd_hit;
    logic              busy;
    logic              line_fill;
    logic              line_wr;
    logic              mem_we;
    logic [NBITS-1:0]  mem_rdata;

    assign idx = mem_if.addr[IDX_W-1:0];
    assign tag = mem_if.addr[NBITS-1:IDX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    mem_backing #(.NBITS(NBITS)) u_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .addr_i  (mem_if.addr),
        .wdata_i (mem_if.wdata),
        .rdata_o (mem_rdata)
    );

    // State, latency counter, held read data and performance counters.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rdata_q  <= '0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    // Next state, stall and line/backing update strobes.
    // NOTE: every output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        hits_d    = hits_q;
        misses_d  = misses_q;
        busy      = 1'b0;
        rd_hit    = 1'b0;
        line_fill = 1'b0;
        line_wr   = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A write wins when both requests are raised together.
                if (mem_if.MemWrite) begin
                    busy    = 1'b1;
                    line_wr = hit;
                    cnt_d   = LAT_LOAD;
                    state_d = WRITE;
                end else if (mem_if.MemRead) begin
                    if (hit) begin
                        rd_hit  = 1'b1;
                        rdata_d = data_q[idx];
                        hits_d  = (hits_q == '1) ? hits_q : hits_q + 1'b1;
                    end else begin
                        busy     = 1'b1;
                        cnt_d    = LAT_LOAD;
                        misses_d = (misses_q == '1) ? misses_q : misses_q + 1'b1;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    line_fill = 1'b1;
                    rdata_d   = mem_rdata;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    mem_we  = ~reset;
                    rdata_d = mem_if.wdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                // The still-held request is the one just completed.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid bits: cleared by reset, set when a fill completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (line_fill) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // Line tag/data storage; a reset edge suppresses any pending update.
    // NOTE: the tag/data arrays are not reset; valid_q alone decides whether
    // their contents mean anything.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (line_fill) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_rdata;
            end else if (line_wr) begin
                data_q[idx] <= mem_if.wdata;
            end
        end
    end

    assign mem_if.busy        = busy;
    assign mem_if.rdata       = rd_hit ? data_q[idx] : rdata_q;
    assign mem_if.read_hits   = hits_q;
    assign mem_if.read_misses = misses_q;
endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus random
// traffic against a behavioural cache model. A second instance with 3-bit
// counters shares the stimulus so counter saturation is exercised too.
module tb_dcache_responder;
    localparam int NBITS   = 8;
    localparam int NLINES  = 8;
    localparam int MEM_LAT = 4;
    localparam int NCNT    = 16;
    localparam int NCNT_S  = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    dcache_responder_if #(.NBITS(NBITS), .NCNT(NCNT))   bus ();
    dcache_responder_if #(.NBITS(NBITS), .NCNT(NCNT_S)) bus_s ();

    assign bus_s.MemRead  = bus.MemRead;
    assign bus_s.MemWrite = bus.MemWrite;
    assign bus_s.addr     = bus.addr;
    assign bus_s.wdata    = bus.wdata;

    dcache_responder #(.NBITS(NBITS), .NLINES(NLINES), .MEM_LAT(MEM_LAT), .NCNT(NCNT)) dut (
        .clock  (clock),
        .reset  (reset),
        .mem_if (bus)
    );

    dcache_responder #(.NBITS(NBITS), .NLINES(NLINES), .MEM_LAT(MEM_LAT), .NCNT(NCNT_S)) dut_s (
        .clock  (clock),
        .reset  (reset),
        .mem_if (bus_s)
    );

    // Behavioural model: backing bytes, and which full address each line holds
    // (-1 = empty). Cached data always equals the backing byte in this model,
    // since writes go through and write hits refresh the line.
    logic [7:0] m_mem [256];
    int         m_line [NLINES];
    int         m_hits;
    int         m_misses;
    logic [7:0] m_last;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NLINES; i++) m_line[i] = -1;
        m_hits   = 0;
        m_misses = 0;
        m_last   = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     32'(bus.busy), 32'd0);
        check({tag, "_rdata"},    32'(bus.rdata), 32'(m_last));
        check({tag, "_hits"},     32'(bus.read_hits), 32'(sat(m_hits, NCNT)));
        check({tag, "_misses"},   32'(bus.read_misses), 32'(sat(m_misses, NCNT)));
        check({tag, "_hits_s"},   32'(bus_s.read_hits), 32'(sat(m_hits, NCNT_S)));
        check({tag, "_misses_s"}, 32'(bus_s.read_misses), 32'(sat(m_misses, NCNT_S)));
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset        = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One complete access: predict, drive, count the stall, check completion,
    // release the request and check the idle cycle that follows.
    task automatic access(input string tag, input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] wd);
        int         idx;
        bit         hit;
        int         exp_busy;
        logic [7:0] exp_rdata;
        int         nb;

        idx = int'(a) % NLINES;
        hit = (m_line[idx] == int'(a));
        if (wr) begin
            exp_busy  = MEM_LAT + 1;
            m_mem[a]  = wd;
            exp_rdata = wd;
        end else begin
            exp_busy  = hit ? 0 : MEM_LAT + 1;
            exp_rdata = m_mem[a];
            if (hit) m_hits++;
            else begin
                m_misses++;
                m_line[idx] = int'(a);
            end
        end
        m_last = exp_rdata;

        @(posedge clock);
        #1;
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.addr     = a;
        bus.wdata    = wd;

        nb = 0;
        @(negedge clock);
        while (bus.busy === 1'b1 && nb <= 3 * MEM_LAT + 4) begin
            nb++;
            @(negedge clock);
        end
        check({tag, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
        check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rdata));

        @(posedge clock);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        @(negedge clock);
        check_idle({tag, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        reset        = 1'b1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        model_reset();
        do_reset();
        @(negedge clock);
        check_idle("reset");

        // 1: cold read miss returns the zero-initialised byte.
        access("t1_rd_miss", 1'b1, 1'b0, 8'h10, 8'h00);
        check("t1_misses_const", 32'(bus.read_misses), 32'd1);
        // 2: write hit, then a read hit in the request cycle.
        access("t2_wr_hit", 1'b0, 1'b1, 8'h10, 8'hA5);
        access("t2_rd_hit", 1'b1, 1'b0, 8'h10, 8'h00);
        check("t2_hits_const", 32'(bus.read_hits), 32'd1);
        // 3: conflict eviction on index 0.
        access("t3_rd_18", 1'b1, 1'b0, 8'h18, 8'h00);
        access("t3_rd_10", 1'b1, 1'b0, 8'h10, 8'h00);
        check("t3_misses_const", 32'(bus.read_misses), 32'd3);
        // 4: write miss does not allocate.
        access("t4_wr_miss", 1'b0, 1'b1, 8'h33, 8'h5C);
        access("t4_rd_33", 1'b1, 1'b0, 8'h33, 8'h00);

        // 5: reset in the 3rd WRITE cycle aborts the backing write.
        @(posedge clock);
        #1;
        bus.MemWrite = 1'b1;
        bus.addr     = 8'h40;
        bus.wdata    = 8'h77;
        repeat (3) @(posedge clock);
        #1;
        reset        = 1'b1;
        bus.MemWrite = 1'b0;
        @(negedge clock);
        check("t5_busy_mid_write", 32'(bus.busy), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        check_idle("t5_after_reset");
        access("t5_rd_40", 1'b1, 1'b0, 8'h40, 8'h00);

        // 6: simultaneous read+write is a write.
        access("t6_rdwr", 1'b1, 1'b1, 8'h22, 8'h11);
        access("t6_rd_22", 1'b1, 1'b0, 8'h22, 8'h00);

        // Random traffic over a small address pool so hits, conflicts and
        // write hits/misses all occur; drives the 3-bit counters to saturation.
        for (int n = 0; n < 200; n++) begin
            logic [7:0] a;
            logic [7:0] wd;
            int         op;
            a  = 8'((($urandom_range(0, 2)) * NLINES) + $urandom_range(0, NLINES - 1));
            wd = 8'($urandom);
            op = $urandom_range(0, 9);
            if (op < 6)       access("rnd_rd",   1'b1, 1'b0, a, wd);
            else if (op < 9)  access("rnd_wr",   1'b0, 1'b1, a, wd);
            else              access("rnd_rdwr", 1'b1, 1'b1, a, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
